data_cache: RTL and testbench

// Direct-mapped, write-through, no-write-allocate data cache between the MEM pipeline stage and data_memory.

---
 rtl/dcache_pkg.sv | 32 +++
 rtl/data_cache_array.sv | 74 +++++++
 rtl/data_cache.sv | 157 +++++++++++++++
 tb/tb_data_cache.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, default geometry and address field helpers for the data cache
package dcache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    localparam int DATA_WIDTH  = 32;
    localparam int NUM_SETS    = 16;
    localparam int BLOCK_WORDS = 4;
    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int WOFF_BITS   = $clog2(BLOCK_WORDS);
    localparam int TAG_BITS    = DATA_WIDTH - INDEX_BITS - WOFF_BITS - 2;

    function automatic logic [1:0] addr_boff(input logic [DATA_WIDTH-1:0] addr);
        return addr[1:0];
    endfunction

    function automatic logic [WOFF_BITS-1:0] addr_woff(input logic [DATA_WIDTH-1:0] addr);
        return addr[WOFF_BITS+1:2];
    endfunction

    function automatic logic [INDEX_BITS-1:0] addr_index(input logic [DATA_WIDTH-1:0] addr);
        return addr[INDEX_BITS+WOFF_BITS+1:WOFF_BITS+2];
    endfunction

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [DATA_WIDTH-1:0] addr);
        return addr[DATA_WIDTH-1:INDEX_BITS+WOFF_BITS+2];
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// rtl/data_cache_array.sv - valid/tag/data storage with combinational lookup and posedge fill/write
module data_cache_array
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BYTE_WIDTH  = 8,
    parameter int NUM_SETS    = 16,
    parameter int BLOCK_WORDS = 4,
    parameter int TAG_BITS    = 24,
    localparam int IDX_W      = $clog2(NUM_SETS),
    localparam int WOFF_W     = $clog2(BLOCK_WORDS),
    localparam int BOFF_W     = $clog2(DATA_WIDTH / BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      rd_index,
    input  logic [WOFF_W-1:0]     rd_woff,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0] rd_word,
    input  logic                  clr_en,
    input  logic [IDX_W-1:0]      clr_index,
    input  logic                  fill_en,
    input  logic                  fill_last,
    input  logic [IDX_W-1:0]      fill_index,
    input  logic [WOFF_W-1:0]     fill_woff,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic [TAG_BITS-1:0]   fill_tag,
    input  logic                  wr_en,
    input  logic                  wr_byte,
    input  logic [IDX_W-1:0]      wr_index,
    input  logic [WOFF_W-1:0]     wr_woff,
    input  logic [BOFF_W-1:0]     wr_boff,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [NUM_SETS-1:0]   valid;
    logic [TAG_BITS-1:0]   tags [NUM_SETS];
    logic [DATA_WIDTH-1:0] data [NUM_SETS][BLOCK_WORDS];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_word  = data[rd_index][rd_woff];

    // A line being refilled is invalid until its last word lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (fill_en && fill_last) begin
            valid[fill_index] <= 1'b1;
        end else if (clr_en) begin
            valid[clr_index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en && fill_last) begin
            tags[fill_index] <= fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            data[fill_index][fill_woff] <= fill_data;
        end else if (wr_en) begin
            if (wr_byte) begin
                data[wr_index][wr_woff][wr_boff*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[BYTE_WIDTH-1:0];
            end else begin
                data[wr_index][wr_woff] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache with refill FSM
module data_cache
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BYTE_WIDTH  = 8,
    parameter int NUM_SETS    = 16,
    parameter int BLOCK_WORDS = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_re_i,
    input  logic                  cpu_we_i,
    input  logic                  cpu_byte_op_i,
    input  logic [DATA_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wd_i,
    output logic [DATA_WIDTH-1:0] cpu_rd_o,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic                  mem_byte_op_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,
    output logic [CNT_WIDTH-1:0]  hit_count_o,
    output logic [CNT_WIDTH-1:0]  miss_count_o
);

    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int WOFF_W = $clog2(BLOCK_WORDS);
    localparam int BOFF_W = $clog2(DATA_WIDTH / BYTE_WIDTH);
    localparam int TAG_W  = DATA_WIDTH - IDX_W - WOFF_W - BOFF_W;
    localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(BLOCK_WORDS - 1);

    state_e state, next_state;
    logic [WOFF_W-1:0] cnt;
    logic [TAG_W-1:0]  lat_tag;
    logic [IDX_W-1:0]  lat_index;

    logic [BOFF_W-1:0] boff;
    logic [WOFF_W-1:0] woff;
    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;

    assign boff  = cpu_addr_i[BOFF_W-1:0];
    assign woff  = cpu_addr_i[BOFF_W +: WOFF_W];
    assign index = cpu_addr_i[BOFF_W+WOFF_W +: IDX_W];
    assign tag   = cpu_addr_i[DATA_WIDTH-1 -: TAG_W];

    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_WIDTH-1:0] line_word;
    logic                  hit;

    assign hit = line_valid && (line_tag == tag);

    logic idle_store, load_req, load_hit, load_miss, fill_en;

    assign idle_store = !rst_i && (state == IDLE) && cpu_we_i;
    assign load_req   = !rst_i && (state == IDLE) && !cpu_we_i && cpu_re_i;
    assign load_hit   = load_req && hit;
    assign load_miss  = load_req && !hit;
    assign fill_en    = !rst_i && (state == REFILL);

    data_cache_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BYTE_WIDTH  (BYTE_WIDTH),
        .NUM_SETS    (NUM_SETS),
        .BLOCK_WORDS (BLOCK_WORDS),
        .TAG_BITS    (TAG_W)
    ) u_array (
        .clk        (clk_i),
        .rst        (rst_i),
        .rd_index   (index),
        .rd_woff    (woff),
        .rd_valid   (line_valid),
        .rd_tag     (line_tag),
        .rd_word    (line_word),
        .clr_en     (load_miss),
        .clr_index  (index),
        .fill_en    (fill_en),
        .fill_last  (cnt == LAST_WORD),
        .fill_index (lat_index),
        .fill_woff  (cnt),
        .fill_data  (mem_rd_i),
        .fill_tag   (lat_tag),
        .wr_en      (idle_store && hit),
        .wr_byte    (cpu_byte_op_i),
        .wr_index   (index),
        .wr_woff    (woff),
        .wr_boff    (boff),
        .wr_data    (cpu_wd_i)
    );

    logic [DATA_WIDTH-1:0] lane;
    assign lane = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, line_word[boff*BYTE_WIDTH +: BYTE_WIDTH]};

    always_comb begin
        next_state    = state;
        stall_o       = 1'b0;
        cpu_rd_o      = '0;
        mem_addr_o    = cpu_addr_i;
        mem_we_o      = 1'b0;
        mem_byte_op_o = cpu_byte_op_i;
        mem_wd_o      = cpu_wd_i;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    if (cpu_we_i) begin
                        mem_we_o = 1'b1;
                    end else if (cpu_re_i) begin
                        if (hit) begin
                            cpu_rd_o = cpu_byte_op_i ? lane : line_word;
                        end else begin
                            stall_o    = 1'b1;
                            next_state = REFILL;
                        end
                    end
                end
                REFILL: begin
                    stall_o       = 1'b1;
                    mem_byte_op_o = 1'b0;
                    mem_addr_o    = {lat_tag, lat_index, cnt, {BOFF_W{1'b0}}};
                    if (cnt == LAST_WORD) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else begin
            state <= next_state;
            if (load_miss) begin
                lat_tag   <= tag;
                lat_index <= index;
                cnt       <= '0;
            end else if (state == REFILL) begin
                cnt <= cnt + WOFF_W'(1);
            end
            if (load_hit) begin
                hit_count_o <= hit_count_o + CNT_WIDTH'(1);
            end
            if (load_miss) begin
                miss_count_o <= miss_count_o + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - self-checking bench for data_cache: directed table, reset-in-refill, random vs model
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re = 1'b0, we = 1'b0, bop = 1'b0;
    logic [31:0] addr = '0, wd = '0;
    logic [31:0] rd, maddr, mwd, mrd;
    logic        stall, mwe, mbop;
    logic [15:0] hc, mc;

    always #5 clk = ~clk;

    data_cache dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cpu_re_i      (re),
        .cpu_we_i      (we),
        .cpu_byte_op_i (bop),
        .cpu_addr_i    (addr),
        .cpu_wd_i      (wd),
        .cpu_rd_o      (rd),
        .stall_o       (stall),
        .mem_addr_o    (maddr),
        .mem_we_o      (mwe),
        .mem_byte_op_o (mbop),
        .mem_wd_o      (mwd),
        .mem_rd_i      (mrd),
        .hit_count_o   (hc),
        .miss_count_o  (mc)
    );

    // data_memory stand-in: 256 KB, combinational read, posedge write
    logic [31:0] mem    [0:65535];
    logic [31:0] shadow [0:65535];

    always_comb mrd = mem[maddr[17:2]];

    always @(posedge clk) begin
        if (mwe) begin
            if (mbop) mem[maddr[17:2]][8*maddr[1:0] +: 8] <= mwd[7:0];
            else      mem[maddr[17:2]] <= mwd;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: cache is transparent to data, so loads return current memory; hit/miss from tag table.
    bit mv   [16];
    int mtag [16];
    int exp_hits, exp_misses;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic model_op(input bit r, input bit w, input bit b, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] erd, output int en);
        int idx;
        int t;
        logic [31:0] word;
        idx  = int'(a >> 4) & 15;
        t    = int'(a >> 8);
        word = shadow[a[17:2]];
        en   = 0;
        erd  = '0;
        if (w) begin
            if (b) shadow[a[17:2]][8*a[1:0] +: 8] = d[7:0];
            else   shadow[a[17:2]] = d;
        end else if (r) begin
            if (!(mv[idx] && mtag[idx] == t)) begin
                exp_misses++;
                en = 5;
                mv[idx]   = 1'b1;
                mtag[idx] = t;
            end
            exp_hits++;
            erd = b ? ((word >> (8 * a[1:0])) & 32'hFF) : word;
        end
    endtask

    task automatic do_op(input bit r, input bit w, input bit b, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] got_rd, output int n,
                         output logic got_we);
        re = r; we = w; bop = b; addr = a; wd = d;
        n = 0;
        @(negedge clk);
        while (stall === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        got_rd = rd;
        got_we = mwe;
        @(posedge clk);
        #1;
        re = 1'b0; we = 1'b0; bop = 1'b0;
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        mem[a[17:2]]    = v;
        shadow[a[17:2]] = v;
    endtask

    typedef struct {
        bit          re, we, bop;
        logic [31:0] addr, wd;
        bit          chk_rd;
        logic [31:0] rd;
        int          stalls, hits, misses;
    } vec_t;

    function automatic vec_t mk(bit r, bit w, bit b, logic [31:0] a, logic [31:0] d, bit c,
                                logic [31:0] erd, int s, int h, int m);
        vec_t v;
        v.re = r; v.we = w; v.bop = b; v.addr = a; v.wd = d; v.chk_rd = c;
        v.rd = erd; v.stalls = s; v.hits = h; v.misses = m;
        return v;
    endfunction

    vec_t tv [12];

    initial begin
        logic [31:0] grd, erd;
        logic        gwe;
        int          n, en;

        for (int i = 0; i < 65536; i++) begin
            mem[i]    = $urandom;
            shadow[i] = mem[i];
        end
        set_word(32'h10000, 32'h0BADC0DE);
        set_word(32'h10004, 32'hDEADBEEF);
        set_word(32'h10100, 32'hCAFEF00D);
        set_word(32'h20000, 32'h11223344);
        model_reset();

        tv[0]  = mk(1, 0, 0, 32'h10004, 0,            1, 32'hDEADBEEF, 5, 1, 1);
        tv[1]  = mk(1, 0, 1, 32'h10006, 0,            1, 32'h000000AD, 0, 2, 1);
        tv[2]  = mk(0, 1, 0, 32'h10008, 32'h12345678, 0, 0,            0, 2, 1);
        tv[3]  = mk(1, 0, 0, 32'h10008, 0,            1, 32'h12345678, 0, 3, 1);
        tv[4]  = mk(1, 0, 0, 32'h10100, 0,            1, 32'hCAFEF00D, 5, 4, 2);
        tv[5]  = mk(1, 0, 0, 32'h10000, 0,            1, 32'h0BADC0DE, 5, 5, 3);
        tv[6]  = mk(0, 1, 1, 32'h20000, 32'hFFFFFF55, 0, 0,            0, 5, 3);
        tv[7]  = mk(1, 0, 1, 32'h20000, 0,            1, 32'h00000055, 5, 6, 4);
        tv[8]  = mk(1, 0, 0, 32'h20000, 0,            1, 32'h11223355, 0, 7, 4);
        tv[9]  = mk(0, 1, 1, 32'h20002, 32'h000000EE, 0, 0,            0, 7, 4);
        tv[10] = mk(1, 0, 0, 32'h20000, 0,            1, 32'h11EE3355, 0, 8, 4);
        tv[11] = mk(1, 0, 1, 32'h20003, 0,            1, 32'h00000011, 0, 9, 4);

        // reset state
        @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_mem_we", {31'b0, mwe}, 32'h0);
        check("rst_rd", rd, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hits", {16'b0, hc}, 32'h0);
        check("rst_misses", {16'b0, mc}, 32'h0);
        @(posedge clk);
        #1;

        foreach (tv[i]) begin
            model_op(tv[i].re, tv[i].we, tv[i].bop, tv[i].addr, tv[i].wd, erd, en);
            do_op(tv[i].re, tv[i].we, tv[i].bop, tv[i].addr, tv[i].wd, grd, n, gwe);
            check($sformatf("vec%0d_stalls", i), n, tv[i].stalls);
            check($sformatf("vec%0d_mem_we", i), {31'b0, gwe}, {31'b0, tv[i].we});
            if (tv[i].chk_rd) check($sformatf("vec%0d_rd", i), grd, tv[i].rd);
            check($sformatf("vec%0d_hits", i), {16'b0, hc}, tv[i].hits);
            check($sformatf("vec%0d_misses", i), {16'b0, mc}, tv[i].misses);
        end

        // reset during the second refill cycle abandons the line
        re = 1'b1; addr = 32'h10004;
        @(negedge clk);
        check("rir_miss_stall", {31'b0, stall}, 32'h1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rir_stall_in_rst", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0; re = 1'b0;
        @(negedge clk);
        check("rir_stall_after", {31'b0, stall}, 32'h0);
        check("rir_hits", {16'b0, hc}, 32'h0);
        check("rir_misses", {16'b0, mc}, 32'h0);
        @(posedge clk);
        #1;
        model_reset();
        model_op(1, 0, 0, 32'h10004, 0, erd, en);
        do_op(1, 0, 0, 32'h10004, 0, grd, n, gwe);
        check("rir_reload_stalls", n, 5);
        check("rir_reload_rd", grd, 32'hDEADBEEF);
        check("rir_reload_misses", {16'b0, mc}, 32'h1);

        // random traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            int          kind;
            logic [31:0] a, d;
            bit          r, w, b;
            kind = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0:       a = 32'h10000;
                1:       a = 32'h20000;
                2:       a = 32'h10100;
                default: a = 32'h3F300;
            endcase
            a = a + $urandom_range(0, 63);
            d = $urandom;
            b = $urandom_range(0, 1);
            if (!b) a = a & ~32'h3;
            r = (kind <= 5);
            w = (kind >= 6 && kind <= 8);
            if (kind == 9) begin
                @(negedge clk);
                check("rnd_idle_stall", {31'b0, stall}, 32'h0);
                check("rnd_idle_rd", rd, 32'h0);
                check("rnd_idle_mem_we", {31'b0, mwe}, 32'h0);
                @(posedge clk);
                #1;
            end else begin
                model_op(r, w, b, a, d, erd, en);
                do_op(r, w, b, a, d, grd, n, gwe);
                check($sformatf("rnd%0d_stalls", k), n, en);
                check($sformatf("rnd%0d_mem_we", k), {31'b0, gwe}, {31'b0, w});
                if (r) check($sformatf("rnd%0d_rd@%h", k, a), grd, erd);
                check($sformatf("rnd%0d_hits", k), {16'b0, hc}, exp_hits & 32'hFFFF);
                check($sformatf("rnd%0d_misses", k), {16'b0, mc}, exp_misses & 32'hFFFF);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
